// File: rtl/sr_mon_pkg.sv
// Shared definitions for the SR-latch monitor: tracked-state encoding,
// expected (q,qbar) per state, and the registered input sample layout.
package sr_mon_pkg;

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_RST     = 2'b01;
  localparam logic [1:0] ST_SET     = 2'b10;
  localparam logic [1:0] ST_FORBID  = 2'b11;

  // Expected {q, qbar} for each checked state.
  localparam logic [1:0] EXP_QQB_RST    = 2'b01;
  localparam logic [1:0] EXP_QQB_SET    = 2'b10;
  localparam logic [1:0] EXP_QQB_FORBID = 2'b00;

  typedef struct packed {
    logic s;
    logic r;
    logic q;
    logic qbar;
  } sample_t;

endpackage

// File: rtl/sr_latch_monitor_if.sv
// Bundles for the SR-latch monitor: the counter control link between the
// monitor and its saturating counter, and the observation bundle of the latch pins.
interface sr_mon_cnt_if #(parameter int CNT_W = 8);
  logic             inc;
  logic             clr;
  logic [CNT_W-1:0] count;

  modport master (output inc, output clr, input count);
  modport slave  (input inc, input clr, output count);
endinterface

interface sr_mon_obs_if #(parameter int CNT_W = 8);
  logic             s;
  logic             r;
  logic             q;
  logic             qbar;
  logic             clr_cnt;
  logic [1:0]       state;
  logic             exp_q;
  logic             mismatch;
  logic             forbidden;
  logic [CNT_W-1:0] error_count;

  modport master (output s, output r, output q, output qbar, output clr_cnt,
                  input state, input exp_q, input mismatch, input forbidden,
                  input error_count);
  modport slave  (input s, input r, input q, input qbar, input clr_cnt,
                  output state, output exp_q, output mismatch, output forbidden,
                  output error_count);
endinterface

// File: rtl/sr_mon_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over
// increment, so an event coincident with clear is dropped.
module sr_mon_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  sr_mon_cnt_if.slave  cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (cnt.clr) begin
      count_d = '0;
    end else if (cnt.inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign cnt.count = count_q;

endmodule

// File: rtl/sr_latch_monitor.sv
// Tracks the state of an external SR latch from its sampled (s,r) and checks
// the sampled (q,qbar) one sample later. Build option: SR_MON_FORBID_CHECK_EN.
module sr_latch_monitor
  import sr_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  input  logic             clr_cnt,
  output logic [1:0]       state,
  output logic             exp_q,
  output logic             mismatch,
  output logic             forbidden,
  output logic [CNT_W-1:0] error_count
);

  sample_t    smp_q, smp_d;
  logic [1:0] state_q, state_d;
  logic       mismatch_q, mismatch_d;
  logic       chk_en;
  logic [1:0] exp_qqb;

  sr_mon_cnt_if #(.CNT_W(CNT_W)) cnt_if ();

  assign smp_d = {s, r, q, qbar};

  // 00 holds the state, except that releasing both inputs from FORBID
  // leaves a NOR latch in a race, so the outcome is unknown.
  always_comb begin
    state_d = state_q;
    case ({smp_q.s, smp_q.r})
      2'b01:   state_d = ST_RST;
      2'b10:   state_d = ST_SET;
      2'b11:   state_d = ST_FORBID;
      default: if (state_q == ST_FORBID) state_d = ST_UNKNOWN;
    endcase
  end

  // The latch output is compared with the state from the previous sample,
  // which gives the latch one cycle to settle.
  always_comb begin
    chk_en  = 1'b0;
    exp_qqb = EXP_QQB_RST;
    case (state_q)
      ST_RST: begin
        chk_en  = 1'b1;
        exp_qqb = EXP_QQB_RST;
      end
      ST_SET: begin
        chk_en  = 1'b1;
        exp_qqb = EXP_QQB_SET;
      end
`ifdef SR_MON_FORBID_CHECK_EN
      ST_FORBID: begin
        chk_en  = 1'b1;
        exp_qqb = EXP_QQB_FORBID;
      end
`else
      ST_FORBID: chk_en = 1'b0;
`endif
      default: chk_en = 1'b0;
    endcase
    mismatch_d = chk_en && ({smp_q.q, smp_q.qbar} != exp_qqb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q      <= '0;
      state_q    <= ST_UNKNOWN;
      mismatch_q <= 1'b0;
    end else begin
      smp_q      <= smp_d;
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
    end
  end

  // The counter steps on the same edge that raises the mismatch pulse.
  assign cnt_if.inc = mismatch_d;
  assign cnt_if.clr = clr_cnt;

  sr_mon_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_if.slave)
  );

  assign state       = state_q;
  assign mismatch    = mismatch_q;
  assign exp_q       = (state_q == ST_SET);
  assign forbidden   = (state_q == ST_FORBID);
  assign error_count = cnt_if.count;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Directed bench for sr_latch_monitor: one default-width instance and one
// CNT_W=2 instance share stimulus; expected values are hand-computed per step.
module tb_sr_latch_monitor;
  import sr_mon_pkg::*;

  logic clk = 1'b0;
  logic rst;

  sr_mon_obs_if #(.CNT_W(8)) mon ();

  logic [1:0] state2;
  logic       exp_q2, mismatch2, forbidden2;
  logic [1:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_latch_monitor #(.CNT_W(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .s           (mon.s),
    .r           (mon.r),
    .q           (mon.q),
    .qbar        (mon.qbar),
    .clr_cnt     (mon.clr_cnt),
    .state       (mon.state),
    .exp_q       (mon.exp_q),
    .mismatch    (mon.mismatch),
    .forbidden   (mon.forbidden),
    .error_count (mon.error_count)
  );

  sr_latch_monitor #(.CNT_W(2)) u_dut_w2 (
    .clk         (clk),
    .rst         (rst),
    .s           (mon.s),
    .r           (mon.r),
    .q           (mon.q),
    .qbar        (mon.qbar),
    .clr_cnt     (mon.clr_cnt),
    .state       (state2),
    .exp_q       (exp_q2),
    .mismatch    (mismatch2),
    .forbidden   (forbidden2),
    .error_count (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare both instances against one hand-computed expectation.
  task automatic chk(input string tag, input logic [1:0] st, input logic mm,
                     input int c8, input int c2);
    check({tag, ".state"},     32'(mon.state),       32'(st));
    check({tag, ".exp_q"},     32'(mon.exp_q),       32'(st == ST_SET));
    check({tag, ".forbidden"}, 32'(mon.forbidden),   32'(st == ST_FORBID));
    check({tag, ".mismatch"},  32'(mon.mismatch),    32'(mm));
    check({tag, ".count"},     32'(mon.error_count), 32'(c8));
    check({tag, ".w2.state"},  32'(state2),          32'(st));
    check({tag, ".w2.exp_q"},  32'(exp_q2),          32'(st == ST_SET));
    check({tag, ".w2.forb"},   32'(forbidden2),      32'(st == ST_FORBID));
    check({tag, ".w2.mism"},   32'(mismatch2),       32'(mm));
    check({tag, ".w2.count"},  32'(count2),          32'(c2));
  endtask

  task automatic step(input logic s_v, input logic r_v, input logic q_v,
                      input logic qb_v, input logic clr_v);
    mon.s       = s_v;
    mon.r       = r_v;
    mon.q       = q_v;
    mon.qbar    = qb_v;
    mon.clr_cnt = clr_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    mon.s       = 1'b0;
    mon.r       = 1'b0;
    mon.q       = 1'b0;
    mon.qbar    = 1'b0;
    mon.clr_cnt = 1'b0;
    #12;
    chk("reset", ST_UNKNOWN, 1'b0, 0, 0);
    rst = 1'b0;

    // Reset held by (s,r)=01 with a well-behaved latch.
    step(0, 1, 0, 1, 0); chk("rst_a", ST_UNKNOWN, 1'b0, 0, 0);
    step(0, 1, 0, 1, 0); chk("rst_b", ST_RST,     1'b0, 0, 0);
    step(0, 1, 0, 1, 0); chk("rst_c", ST_RST,     1'b0, 0, 0);

    // Set with q stuck low for three checked samples.
    step(1, 0, 0, 1, 0); chk("set_a", ST_RST, 1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("set_b", ST_SET, 1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("set_c", ST_SET, 1'b1, 1, 1);
    step(1, 0, 0, 1, 0); chk("set_d", ST_SET, 1'b1, 2, 2);
    step(1, 0, 1, 0, 0); chk("set_e", ST_SET, 1'b1, 3, 3);
    step(1, 0, 1, 0, 0); chk("set_f", ST_SET, 1'b0, 3, 3);

    // Forbidden input, then release into the race; q=1 while in FORBID.
    step(1, 1, 1, 0, 0); chk("forb_g", ST_SET,    1'b0, 3, 3);
    step(0, 0, 1, 0, 0); chk("forb_h", ST_FORBID, 1'b0, 3, 3);
    step(0, 0, 1, 0, 0);
`ifdef SR_MON_FORBID_CHECK_EN
    chk("forb_i", ST_UNKNOWN, 1'b1, 4, 3);
    step(0, 0, 1, 0, 0); chk("forb_j", ST_UNKNOWN, 1'b0, 4, 3);
`else
    chk("forb_i", ST_UNKNOWN, 1'b0, 3, 3);
    step(0, 0, 1, 0, 0); chk("forb_j", ST_UNKNOWN, 1'b0, 3, 3);
`endif
    step(0, 0, 1, 0, 1); chk("clr_k", ST_UNKNOWN, 1'b0, 0, 0);

    // Saturation of the 2-bit counter, then clear coincident with a mismatch.
    step(1, 0, 1, 0, 0); chk("sat_l", ST_UNKNOWN, 1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("sat_m", ST_SET,     1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("sat_1", ST_SET, 1'b1, 1, 1);
    step(1, 0, 0, 1, 0); chk("sat_2", ST_SET, 1'b1, 2, 2);
    step(1, 0, 0, 1, 0); chk("sat_3", ST_SET, 1'b1, 3, 3);
    step(1, 0, 0, 1, 0); chk("sat_4", ST_SET, 1'b1, 4, 3);
    step(1, 0, 0, 1, 0); chk("sat_5", ST_SET, 1'b1, 5, 3);
    step(1, 0, 0, 1, 1); chk("sat_clr", ST_SET, 1'b1, 0, 0);
    step(1, 0, 1, 0, 0); chk("sat_7",   ST_SET, 1'b1, 1, 1);
    step(1, 0, 1, 0, 0); chk("sat_8",   ST_SET, 1'b0, 1, 1);

    // Build state=SET, count=2, then pulse rst between clock edges.
    step(1, 0, 1, 0, 1); chk("ar_p",  ST_SET, 1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("ar_q1", ST_SET, 1'b0, 0, 0);
    step(1, 0, 0, 1, 0); chk("ar_q2", ST_SET, 1'b1, 1, 1);
    step(1, 0, 1, 0, 0); chk("ar_q3", ST_SET, 1'b1, 2, 2);
    step(1, 0, 1, 0, 0); chk("ar_q4", ST_SET, 1'b0, 2, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", ST_UNKNOWN, 1'b0, 0, 0);
    #1;
    rst = 1'b0;

    // First edge after reset carries a bad q: no check while UNKNOWN.
    step(1, 0, 0, 1, 0); chk("post_r1", ST_UNKNOWN, 1'b0, 0, 0);
    step(1, 0, 1, 0, 0); chk("post_r2", ST_SET,     1'b0, 0, 0);
    step(1, 0, 1, 0, 0); chk("post_r3", ST_SET,     1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_monitor.md
SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the mismatch counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s  input  1  set input as driven into the latch under observation.
REQ-005 SHALL have port r  input  1  reset input as driven into the latch under observation.
REQ-006 SHALL have port q  input  1  latch true output.
REQ-007 SHALL have port qbar  input  1  latch complement output.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of error_count.
REQ-009 SHALL have port state  output  2  tracked latch state: UNKNOWN=00, RST_ST=01, SET_ST=10, FORBID=11.
REQ-010 SHALL have port exp_q  output  1  expected q for the tracked state: 1 in SET_ST, 0 otherwise.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse when the checked (q,qbar) differs from expectation.
REQ-012 SHALL have port forbidden  output  1  high while state==FORBID.
REQ-013 SHALL have port error_count  output  CNT_W  saturating count of mismatch pulses.

Function
REQ-014 SHALL register s, r, q, qbar on every rising clk edge; all decisions use the registered samples.
REQ-015 SHALL update state from the sampled (s,r): 01 -> RST_ST; 10 -> SET_ST; 11 -> FORBID; 00 -> hold, except FORBID with 00 -> UNKNOWN (NOR-latch race).
REQ-016 SHALL check the sampled (q,qbar) at edge N against the state held after edge N-1 (one-cycle latency for latch settling).
REQ-017 SHALL expect (q,qbar)=(0,1) in RST_ST and (1,0) in SET_ST; no check in UNKNOWN.
REQ-018 SHALL assert mismatch for exactly one cycle per failing check; consecutive failing checks produce consecutive pulses.
REQ-019 SHALL increment error_count by 1 per mismatch pulse and saturate at 2^CNT_W-1, never wrapping.
REQ-020 SHALL zero error_count on clr_cnt; clr_cnt coincident with mismatch clears and the mismatch is not counted; mismatch itself still pulses.
REQ-021 SHALL derive exp_q and forbidden combinationally from state only.

Reset
REQ-022 SHALL on rst force state=UNKNOWN, mismatch=0, error_count=0 and all sample registers to 0, immediately and independent of clk.
REQ-023 SHALL, after rst deasserts mid-sequence, perform no check on the first edge (state UNKNOWN) and resume normal tracking from that edge's (s,r).

Configuration
REQ-024 SHALL, with SR_MON_FORBID_CHECK_EN defined, expect (q,qbar)=(0,0) in FORBID and flag mismatch otherwise.
REQ-025 SHALL, without SR_MON_FORBID_CHECK_EN, perform no check in FORBID; forbidden still asserts.

Structure
REQ-026 SHALL place the state encoding constants and the per-state expected (q,qbar) constants in shared package sr_mon_pkg.
REQ-027 SHALL implement the saturating counter with clear as sub-module sr_mon_sat_counter, parameterised by CNT_W.
REQ-028 SHALL keep the state register, sample registers and check logic in sr_latch_monitor itself.

Verification
REQ-029 SHALL cover: rst pulse, then (s,r)=01 for 2 cycles with correct latch -> state=01, exp_q=0, mismatch never high, error_count=0.
REQ-030 SHALL cover: (s,r)=10 held, q forced 0/qbar 1 for 3 cycles -> state=10, three consecutive mismatch pulses, error_count=3.
REQ-031 SHALL cover: (s,r)=11 then 00 -> forbidden=1 one state, then state=00 (UNKNOWN); with SR_MON_FORBID_CHECK_EN and q=1 in FORBID -> one mismatch; without -> none.
REQ-032 SHALL cover: CNT_W=2, 5 forced mismatches -> error_count sticks at 3; clr_cnt coincident with 6th mismatch -> error_count=0, mismatch pulses.
REQ-033 SHALL cover: asynchronous rst asserted between edges while state=10, error_count=2 -> outputs zero before next edge; first post-reset edge produces no mismatch.
